// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: default geometry, pointer/count width functions and
// the per-cycle transfer classification used by the occupancy counter.
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    // Pointer addresses 0..depth-1; keep at least one bit for tiny depths.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count spans 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH,
    parameter int depth = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [ptr_width(depth)-1:0] waddr,
    input  logic [width-1:0]            wdata,
    input  logic [ptr_width(depth)-1:0] raddr,
    output logic [width-1:0]            rdata
);

    logic [width-1:0] mem [0:depth-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky error flags, synchronous flush and selectable FWFT read mode.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int fifo_width          = DEFAULT_WIDTH,
    parameter int fifo_depth          = DEFAULT_DEPTH,
    parameter int almost_full_thresh  = fifo_depth - 2,
    parameter int almost_empty_thresh = 2,
    parameter int fwft                = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic                            w_en,
    input  logic [fifo_width-1:0]           data_in,
    input  logic                            r_en,
    output logic [fifo_width-1:0]           data_out,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic [$clog2(fifo_depth+1)-1:0] count,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int PW = ptr_width(fifo_depth);
    localparam int CW = $clog2(fifo_depth + 1);

    logic [PW-1:0]         w_ptr;
    logic [PW-1:0]         r_ptr;
    logic [fifo_width-1:0] rd_word;
    logic                  wr_ok;
    logic                  rd_ok;
    fifo_op_e              op;

    // Explicit wrap so non-power-of-two depths never address past the array.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(fifo_depth - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ok = w_en & ~full & ~clr;
        rd_ok = r_en & ~empty & ~clr;
        op    = fifo_op_e'({wr_ok, rd_ok});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                w_ptr <= ptr_inc(w_ptr);
            end
            if (rd_ok) begin
                r_ptr <= ptr_inc(r_ptr);
            end
            case (op)
                OP_WRITE: count <= count + CW'(1);
                OP_READ:  count <= count - CW'(1);
                default:  count <= count;
            endcase
            if (w_en && full) begin
                overflow <= 1'b1;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign full         = (count == CW'(fifo_depth));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(almost_full_thresh));
    assign almost_empty = (count <= CW'(almost_empty_thresh));

    fifo_mem #(
        .width (fifo_width),
        .depth (fifo_depth)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (w_ptr),
        .wdata (data_in),
        .raddr (r_ptr),
        .rdata (rd_word)
    );

    generate
        if (fwft != 0) begin : g_fwft
            assign data_out = empty ? '0 : rd_word;
        end else begin : g_reg
            // rd_ok already excludes clr, so a flush leaves the last word visible.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_out <= '0;
                end else if (rd_ok) begin
                    data_out <= rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: depth-8 registered-read FIFO (vector table plus corner
// sequences) and a depth-5 FWFT FIFO.
module tb_param_sync_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        clr0, w0, r0;
    logic [15:0] din0, dout0;
    logic        full0, empty0, af0, ae0, ovf0, udf0;
    logic [3:0]  cnt0;

    logic        clr1, w1, r1;
    logic [15:0] din1, dout1;
    logic        full1, empty1, af1, ae1, ovf1, udf1;
    logic [2:0]  cnt1;

    param_sync_fifo #(
        .fifo_width(16), .fifo_depth(8), .almost_full_thresh(6),
        .almost_empty_thresh(2), .fwft(0)
    ) dut0 (
        .clk(clk), .rst(rst), .clr(clr0), .w_en(w0), .data_in(din0), .r_en(r0),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0)
    );

    param_sync_fifo #(
        .fifo_width(16), .fifo_depth(5), .almost_full_thresh(3),
        .almost_empty_thresh(2), .fwft(1)
    ) dut1 (
        .clk(clk), .rst(rst), .clr(clr1), .w_en(w1), .data_in(din1), .r_en(r1),
        .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1)
    );

    // flags packing: {full, empty, almost_full, almost_empty, overflow, underflow}
    typedef struct {
        logic        w_en;
        logic        r_en;
        logic        clr;
        logic [15:0] din;
        logic [15:0] dout;
        int          cnt;
        logic [5:0]  flags;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mkv(input logic w, input logic r, input logic c,
                                 input logic [15:0] d, input logic [15:0] q,
                                 input int n, input logic [5:0] f);
        vec_t v;
        v.w_en = w; v.r_en = r; v.clr = c; v.din = d;
        v.dout = q; v.cnt = n; v.flags = f;
        return v;
    endfunction

    function automatic logic [5:0] flags0();
        return {full0, empty0, af0, ae0, ovf0, udf0};
    endfunction

    function automatic logic [5:0] flags1();
        return {full1, empty1, af1, ae1, ovf1, udf1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk0(input string name, input logic [15:0] q, input int n, input logic [5:0] f);
        chk({name, " data_out"}, 32'(dout0), 32'(q));
        chk({name, " count"}, 32'(cnt0), 32'(n));
        chk({name, " flags"}, 32'(flags0()), 32'(f));
    endtask

    task automatic chk1(input string name, input logic [15:0] q, input int n, input logic [5:0] f);
        chk({name, " data_out"}, 32'(dout1), 32'(q));
        chk({name, " count"}, 32'(cnt1), 32'(n));
        chk({name, " flags"}, 32'(flags1()), 32'(f));
    endtask

    task automatic cyc0(input logic w, input logic r, input logic c, input logic [15:0] d);
        w0 = w; r0 = r; clr0 = c; din0 = d;
        @(posedge clk);
        #1;
        w0 = 1'b0; r0 = 1'b0; clr0 = 1'b0;
    endtask

    task automatic cyc1(input logic w, input logic r, input logic c, input logic [15:0] d);
        w1 = w; r1 = r; clr1 = c; din1 = d;
        @(posedge clk);
        #1;
        w1 = 1'b0; r1 = 1'b0; clr1 = 1'b0;
    endtask

    initial begin
        w0 = 0; r0 = 0; clr0 = 0; din0 = '0;
        w1 = 0; r1 = 0; clr1 = 0; din1 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk0("reset dut0", 16'h0, 0, 6'b010100);
        chk1("reset dut1", 16'h0, 0, 6'b010100);
        rst = 1'b0;

        // Fill to full, overflow attempt, drain in order, underflow, flush.
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mkv(1, 0, 0, 16'(k), 16'h0, k,
                               {k == 8, 1'b0, k >= 6, k <= 2, 1'b0, 1'b0}));
        vecs.push_back(mkv(1, 0, 0, 16'hDEAD, 16'h0, 8, 6'b101010));
        for (int j = 1; j <= 8; j++)
            vecs.push_back(mkv(0, 1, 0, 16'h0, 16'(j), 8 - j,
                               {1'b0, j == 8, (8 - j) >= 6, (8 - j) <= 2, 1'b1, 1'b0}));
        vecs.push_back(mkv(0, 1, 0, 16'h0, 16'h0008, 0, 6'b010111));
        vecs.push_back(mkv(0, 0, 1, 16'h0, 16'h0008, 0, 6'b010100));

        foreach (vecs[i]) begin
            cyc0(vecs[i].w_en, vecs[i].r_en, vecs[i].clr, vecs[i].din);
            chk0($sformatf("vec%0d", i), vecs[i].dout, vecs[i].cnt, vecs[i].flags);
        end

        // Simultaneous read/write at count 3 across pointer wrap.
        for (int i = 0; i < 3; i++) cyc0(1, 0, 0, 16'(16'h10 + i));
        chk("prefill count", 32'(cnt0), 32'd3);
        for (int i = 0; i < 20; i++) begin
            cyc0(1, 1, 0, 16'(16'h13 + i));
            chk($sformatf("rw%0d data_out", i), 32'(dout0), 32'(16'h10 + i));
            chk($sformatf("rw%0d count", i), 32'(cnt0), 32'd3);
        end
        for (int i = 0; i < 5; i++) cyc0(1, 0, 0, 16'(16'h27 + i));
        chk0("refill", 16'h0023, 8, 6'b101000);
        cyc0(1, 1, 0, 16'hBEEF);
        chk0("rw at full", 16'h0024, 7, 6'b001010);
        cyc0(1, 0, 0, 16'h002C);
        chk0("write after freed slot", 16'h0024, 8, 6'b101010);
        for (int i = 0; i < 8; i++) begin
            cyc0(0, 1, 0, 16'h0);
            chk($sformatf("drain%0d data_out", i), 32'(dout0), 32'(16'h25 + i));
        end
        chk0("drained", 16'h002C, 0, 6'b010110);
        cyc0(1, 1, 0, 16'h0055);
        chk0("rw at empty", 16'h002C, 1, 6'b000111);
        cyc0(0, 1, 0, 16'h0);
        chk0("read back 55", 16'h0055, 0, 6'b010111);

        // Flush with a concurrent write: write must be dropped.
        cyc0(0, 0, 1, 16'h0);
        for (int i = 0; i < 4; i++) cyc0(1, 0, 0, 16'(16'h60 + i));
        chk("fill4 count", 32'(cnt0), 32'd4);
        cyc0(1, 0, 1, 16'h0099);
        chk0("clr+w", 16'h0055, 0, 6'b010100);
        cyc0(1, 0, 0, 16'h0077);
        cyc0(0, 1, 0, 16'h0);
        chk0("post clr read", 16'h0077, 0, 6'b010100);

        // Asynchronous reset in the middle of a write burst.
        cyc0(0, 1, 0, 16'h0);
        chk("udf before rst", 32'(udf0), 32'd1);
        w0 = 1'b1; din0 = 16'h0080;
        @(posedge clk);
        #1 din0 = 16'h0081;
        @(posedge clk);
        #1 chk("burst count", 32'(cnt0), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk0("async rst dut0", 16'h0, 0, 6'b010100);
        w0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // FWFT, depth 5.
        cyc1(1, 0, 0, 16'h000A);
        chk1("fwft w A", 16'h000A, 1, 6'b000100);
        cyc1(1, 0, 0, 16'h000B);
        chk1("fwft w B", 16'h000A, 2, 6'b000100);
        cyc1(0, 1, 0, 16'h0);
        chk1("fwft pop1", 16'h000B, 1, 6'b000100);
        cyc1(0, 1, 0, 16'h0);
        chk1("fwft pop2", 16'h0000, 0, 6'b010100);
        for (int i = 1; i <= 5; i++) cyc1(1, 0, 0, 16'(i));
        chk1("fwft full", 16'h0001, 5, 6'b101000);
        cyc1(1, 0, 0, 16'h0006);
        chk1("fwft ovf", 16'h0001, 5, 6'b101010);
        cyc1(0, 1, 0, 16'h0);
        chk1("fwft pop wrap", 16'h0002, 4, 6'b001010);
        cyc1(1, 0, 1, 16'h0007);
        chk1("fwft clr", 16'h0000, 0, 6'b010100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
